// File: rtl/mod_counter_casc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_counter_casc : modulo-N up/down counter, binary or packed BCD, with
// 74x163-style enp/ent cascade enables and ripple-carry out.  Rev 1.0
// ---------------------------------------------------------------------------
module mod_counter_casc #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 60,
    parameter bit BCD     = 1'b0,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] qout,
    output logic             rco,
    output logic             wrap,
    output logic             lderr
);

    localparam int c_NDIG = WIDTH / 4;

    function automatic logic [WIDTH-1:0] f_enc(input int v);
        logic [WIDTH-1:0] r;
        int               t;
        r = '0;
        t = v;
        if (BCD) begin
            for (int i = 0; i < c_NDIG; i++) begin
                r[i*4 +: 4] = 4'(t % 10);
                t           = t / 10;
            end
        end else begin
            r = WIDTH'(t);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = q;
        carry = 1'b1;
        if (BCD) begin
            for (int i = 0; i < c_NDIG; i++) begin
                if (carry) begin
                    if (q[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end else begin
            r = q + WIDTH'(1);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_dec(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        logic             borrow;
        r      = q;
        borrow = 1'b1;
        if (BCD) begin
            for (int i = 0; i < c_NDIG; i++) begin
                if (borrow) begin
                    if (q[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                    end else begin
                        r[i*4 +: 4] = q[i*4 +: 4] - 4'd1;
                        borrow      = 1'b0;
                    end
                end
            end
        end else begin
            r = q - WIDTH'(1);
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] c_MAX = f_enc(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST = f_enc(RST_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_lderr;
    logic             w_nib_ok;
    logic             w_din_ok;
    logic             w_term;
    logic             w_cnt;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    // Valid BCD compares in the same order as binary, so one magnitude test covers both modes.
    always_comb begin
        w_nib_ok = 1'b1;
        for (int i = 0; i < c_NDIG; i++) begin
            if (din[i*4 +: 4] > 4'd9) begin
                w_nib_ok = 1'b0;
            end
        end
    end

    assign w_din_ok = (din <= c_MAX) && (!BCD || w_nib_ok);
    assign w_term   = up ? (r_q == c_MAX) : (r_q == '0);
    assign w_cnt    = enp && ent;
    assign w_inc    = f_inc(r_q);
    assign w_dec    = f_dec(r_q);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q     <= c_RST;
            r_wrap  <= 1'b0;
            r_lderr <= 1'b0;
        end else if (sclr) begin
            r_q     <= c_RST;
            r_wrap  <= 1'b0;
            r_lderr <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
            if (w_din_ok) begin
                r_q <= din;
            end else begin
                r_q     <= '0;
                r_lderr <= 1'b1;
            end
        end else if (w_cnt) begin
            r_wrap <= w_term;
            if (w_term) begin
                r_q <= up ? '0 : c_MAX;
            end else begin
                r_q <= up ? w_inc : w_dec;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign qout  = r_q;
    assign rco   = ent && w_term;
    assign wrap  = r_wrap;
    assign lderr = r_lderr;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_casc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mod_counter_casc : four counter instances (BCD 60, binary 10, BCD 60->24
// cascade) checked every cycle against a natural-number model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_mod_counter_casc;

    logic       clk = 1'b0;
    logic       clrn;
    logic [3:0] s_sclr, s_load, s_enp, s_ent, s_up;
    logic [7:0] s_din [4];
    logic [7:0] q_a, q_c1, q_c2;
    logic [3:0] q_b;
    logic [3:0] w_rco, w_wrap, w_lerr;

    int m_v [4];
    bit m_w [4];
    bit m_l [4];
    bit chk_en = 1'b0;
    int n_tot  = 0;
    int n_bad  = 0;

    always #5 clk = ~clk;

    mod_counter_casc #(.WIDTH(8), .MODULUS(60), .BCD(1'b1), .RST_VAL(0)) u_a (
        .clk(clk), .clrn(clrn), .sclr(s_sclr[0]), .load(s_load[0]), .din(s_din[0]),
        .enp(s_enp[0]), .ent(s_ent[0]), .up(s_up[0]), .qout(q_a),
        .rco(w_rco[0]), .wrap(w_wrap[0]), .lderr(w_lerr[0]));

    mod_counter_casc #(.WIDTH(4), .MODULUS(10), .BCD(1'b0), .RST_VAL(3)) u_b (
        .clk(clk), .clrn(clrn), .sclr(s_sclr[1]), .load(s_load[1]), .din(s_din[1][3:0]),
        .enp(s_enp[1]), .ent(s_ent[1]), .up(s_up[1]), .qout(q_b),
        .rco(w_rco[1]), .wrap(w_wrap[1]), .lderr(w_lerr[1]));

    mod_counter_casc #(.WIDTH(8), .MODULUS(60), .BCD(1'b1), .RST_VAL(0)) u_c1 (
        .clk(clk), .clrn(clrn), .sclr(s_sclr[2]), .load(s_load[2]), .din(s_din[2]),
        .enp(s_enp[2]), .ent(s_ent[2]), .up(s_up[2]), .qout(q_c1),
        .rco(w_rco[2]), .wrap(w_wrap[2]), .lderr(w_lerr[2]));

    mod_counter_casc #(.WIDTH(8), .MODULUS(24), .BCD(1'b1), .RST_VAL(0)) u_c2 (
        .clk(clk), .clrn(clrn), .sclr(s_sclr[3]), .load(s_load[3]), .din(s_din[3]),
        .enp(s_enp[3]), .ent(w_rco[2]), .up(s_up[3]), .qout(q_c2),
        .rco(w_rco[3]), .wrap(w_wrap[3]), .lderr(w_lerr[3]));

    function automatic int modof(int u);
        return (u == 1) ? 10 : (u == 3) ? 24 : 60;
    endfunction

    function automatic int rstof(int u);
        return (u == 1) ? 3 : 0;
    endfunction

    function automatic bit bcdof(int u);
        return u != 1;
    endfunction

    function automatic logic [7:0] enc(int v, bit bcd);
        return bcd ? 8'((v / 10) * 16 + (v % 10)) : 8'(v);
    endfunction

    function automatic logic [7:0] dut_q(int u);
        case (u)
            0:       return q_a;
            1:       return {4'h0, q_b};
            2:       return q_c1;
            default: return q_c2;
        endcase
    endfunction

    function automatic bit m_term(int u);
        return s_up[u] ? (m_v[u] == modof(u) - 1) : (m_v[u] == 0);
    endfunction

    function automatic bit m_ent(int u);
        return (u == 3) ? (s_ent[2] && m_term(2)) : s_ent[u];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 4; u++) begin
            m_v[u] = rstof(u);
            m_w[u] = 1'b0;
            m_l[u] = 1'b0;
        end
    endtask

    // Next state from the current inputs, applied just after the rising edge.
    task automatic cyc();
        int  nv [4];
        bit  nw [4];
        bit  nl [4];
        int  d;
        bit  ok;
        for (int u = 0; u < 4; u++) begin
            nv[u] = m_v[u];
            nw[u] = 1'b0;
            nl[u] = m_l[u];
            d     = (u == 1) ? int'(s_din[1][3:0]) : int'(s_din[u]);
            if (!clrn || s_sclr[u]) begin
                nv[u] = rstof(u);
                nl[u] = 1'b0;
            end else if (s_load[u]) begin
                if (bcdof(u)) begin
                    ok = (d % 16 <= 9) && (d / 16 <= 9) && ((d / 16) * 10 + d % 16 < modof(u));
                    d  = (d / 16) * 10 + d % 16;
                end else begin
                    ok = d < modof(u);
                end
                if (ok) nv[u] = d;
                else begin
                    nv[u] = 0;
                    nl[u] = 1'b1;
                end
            end else if (s_enp[u] && m_ent(u)) begin
                if (s_up[u]) nv[u] = (m_v[u] + 1) % modof(u);
                else         nv[u] = (m_v[u] + modof(u) - 1) % modof(u);
                nw[u] = m_term(u);
            end
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) begin
            m_v[u] = nv[u];
            m_w[u] = nw[u];
            m_l[u] = nl[u];
        end
    endtask

    task automatic areset();
        clrn = 1'b0;
        #1;
        model_reset();
        check("async_q", q_a, 8'h00);
        check("async_wrap", w_wrap[0], 1'b0);
        check("async_lderr", w_lerr[0], 1'b0);
        clrn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 4; u++) begin
                check($sformatf("model_q%0d", u), dut_q(u), enc(m_v[u], bcdof(u)));
                check($sformatf("model_wrap%0d", u), w_wrap[u], m_w[u]);
                check($sformatf("model_lderr%0d", u), w_lerr[u], m_l[u]);
                check($sformatf("model_rco%0d", u), w_rco[u], m_ent(u) && m_term(u));
            end
        end
    end

    initial begin
        int steps, wraps;
        logic [7:0] prev;
        clrn   = 1'b0;
        s_sclr = 4'b0;
        s_load = 4'b0;
        s_enp  = 4'b1000;
        s_ent  = 4'b0;
        s_up   = 4'b1000;
        for (int u = 0; u < 4; u++) s_din[u] = 8'h00;
        model_reset();
        repeat (3) cyc();
        clrn   = 1'b1;
        chk_en = 1'b1;
        check("rst_qa", q_a, 8'h00);
        check("rst_qb", q_b, 4'd3);

        // count to 37, asynchronous clear between edges, resume
        s_enp[0] = 1'b1; s_ent[0] = 1'b1; s_up[0] = 1'b1;
        repeat (37) cyc();
        check("cnt37", q_a, 8'h37);
        areset();
        cyc();
        check("resume01", q_a, 8'h01);

        // full up pass with wrap
        s_sclr[0] = 1'b1;
        cyc();
        s_sclr[0] = 1'b0;
        repeat (58) cyc();
        check("at58", q_a, 8'h58);
        check("rco58", w_rco[0], 1'b0);
        cyc();
        check("at59", q_a, 8'h59);
        check("rco59", w_rco[0], 1'b1);
        cyc();
        check("wrap_q", q_a, 8'h00);
        check("wrap_pulse", w_wrap[0], 1'b1);
        check("wrap_rco", w_rco[0], 1'b0);
        cyc();
        check("wrap_gone", w_wrap[0], 1'b0);

        // enable gating at 59
        s_load[0] = 1'b1; s_din[0] = 8'h59;
        cyc();
        s_load[0] = 1'b0; s_ent[0] = 1'b0;
        #1 check("ent0_rco", w_rco[0], 1'b0);
        cyc();
        check("ent0_hold", q_a, 8'h59);
        s_ent[0] = 1'b1; s_enp[0] = 1'b0;
        #1 check("enp0_rco", w_rco[0], 1'b1);
        cyc();
        check("enp0_hold", q_a, 8'h59);
        check("enp0_wrap", w_wrap[0], 1'b0);

        // loads and priority
        s_load[0] = 1'b1; s_din[0] = 8'h45;
        cyc();
        check("ld45", q_a, 8'h45);
        s_din[0] = 8'h4A;
        cyc();
        check("ld4A_q", q_a, 8'h00);
        check("ld4A_err", w_lerr[0], 1'b1);
        s_din[0] = 8'h61;
        cyc();
        check("ld61_q", q_a, 8'h00);
        check("ld61_err", w_lerr[0], 1'b1);
        s_din[0] = 8'h45;
        cyc();
        check("sticky_q", q_a, 8'h45);
        check("sticky_err", w_lerr[0], 1'b1);
        s_sclr[0] = 1'b1; s_enp[0] = 1'b1;
        cyc();
        check("sclr_q", q_a, 8'h00);
        check("sclr_err", w_lerr[0], 1'b0);
        s_sclr[0] = 1'b0; s_load[0] = 1'b0; s_enp[0] = 1'b0; s_ent[0] = 1'b0;

        // binary mod-10 down wrap
        s_load[1] = 1'b1; s_din[1] = 8'h01; s_up[1] = 1'b0; s_enp[1] = 1'b1; s_ent[1] = 1'b1;
        cyc();
        s_load[1] = 1'b0;
        check("dn_1", q_b, 4'd1);
        cyc();
        check("dn_0", q_b, 4'd0);
        check("dn_rco", w_rco[1], 1'b1);
        cyc();
        check("dn_9", q_b, 4'd9);
        check("dn_wrap", w_wrap[1], 1'b1);
        cyc();
        check("dn_8", q_b, 4'd8);
        check("dn_wrap_gone", w_wrap[1], 1'b0);
        s_enp[1] = 1'b0; s_ent[1] = 1'b0;

        // 60 x 24 cascade over a full day
        s_enp[2] = 1'b1; s_ent[2] = 1'b1; s_up[2] = 1'b1;
        steps = 0; wraps = 0; prev = q_c2;
        repeat (1440) begin
            cyc();
            if (q_c2 !== prev) steps++;
            prev = q_c2;
            if (w_wrap[3]) wraps++;
        end
        check("casc_steps", steps, 24);
        check("casc_wraps", wraps, 1);
        check("casc_q1", q_c1, 8'h00);
        check("casc_q2", q_c2, 8'h00);

        // randomized traffic on the three driven instances
        repeat (2000) begin
            for (int u = 0; u < 3; u++) begin
                s_sclr[u] = ($urandom % 32) == 0;
                s_load[u] = ($urandom % 8) == 0;
                s_enp[u]  = ($urandom % 4) != 0;
                s_ent[u]  = ($urandom % 4) != 0;
                s_up[u]   = ($urandom % 3) != 0;
                if (u == 1)              s_din[u] = 8'($urandom % 16);
                else if ($urandom % 2)   s_din[u] = enc($urandom % 60, 1'b1);
                else                     s_din[u] = 8'($urandom % 256);
            end
            if (($urandom % 200) == 0) areset();
            cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
